// File: rtl/mem_write_arbiter_pkg.sv
// Shared encodings for the memory write arbiter: store sizes, region codes
// and the arbitration state type.
package mem_wr_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    // addr[31:28] region codes
    localparam logic [3:0] REGION_DMEM = 4'h1;
    localparam logic [3:0] REGION_IMEM = 4'h2;
    localparam logic [3:0] REGION_BOTH = 4'h3;

    typedef enum logic [1:0] {
        StIdle,
        StCoreLast,
        StAuxLast,
        StAuxLocked
    } arb_state_e;

endpackage

// File: rtl/mem_write_arbiter_byte_lane_encoder.sv
// Combinational byte-lane encoder: turns a store size and byte offset into a
// write mask, lane-aligned data and a misalignment flag.
module byte_lane_encoder
    import mem_wr_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       size,
    input  logic [1:0]       offset,
    input  logic [WIDTH-1:0] data,
    output logic [3:0]       mask,
    output logic [WIDTH-1:0] wdata,
    output logic             misaligned
);

    // Sub-word stores are shifted onto their lanes; words and illegal sizes pass through.
    always_comb begin
        mask       = 4'b0000;
        wdata      = data;
        misaligned = 1'b0;
        unique case (size)
            SIZE_BYTE: begin
                mask  = 4'b0001 << offset;
                wdata = data << {offset, 3'b000};
            end
            SIZE_HALF: begin
                mask       = 4'b0011 << offset;
                wdata      = data << {offset, 3'b000};
                misaligned = offset[0];
            end
            SIZE_WORD: begin
                mask       = 4'b1111;
                misaligned = (offset != 2'b00);
            end
            SIZE_ILL: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Two-requester store arbiter (core and aux loader) feeding DMEM/IMEM byte
// write ports. Grants are combinational; the accepted command is encoded and
// registered, so memory-side outputs appear one cycle after the handshake.
module mem_write_arbiter
    import mem_wr_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [WIDTH-1:0]  c_addr,
    input  logic [WIDTH-1:0]  c_data,
    input  logic [1:0]        c_size,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [WIDTH-1:0]  a_addr,
    input  logic [WIDTH-1:0]  a_data,
    input  logic [1:0]        a_size,
    input  logic              a_lock,
    input  logic              imem_wr_allow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [3:0]        dmem_we,
    output logic [3:0]        imem_we,
    output logic              err_pulse,
    output logic              err_src,
    output logic [7:0]        err_cnt
);

    arb_state_e       state;
    logic             grant_c;
    logic             grant_a;
    logic             handshake;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic [1:0]       sel_size;
    logic [3:0]       enc_mask;
    logic [WIDTH-1:0] enc_wdata;
    logic             enc_misaligned;
    logic             dmem_hit;
    logic             imem_hit;
    logic             unused_addr_bits;

    // Grant selection: alternate on contention, lock shuts the core out;
    // reset low masks both readies immediately.
    always_comb begin
        grant_c = 1'b0;
        grant_a = 1'b0;
        if (rst_n) begin
            if (state == StAuxLocked) begin
                grant_a = a_valid;
            end else if (c_valid && a_valid) begin
                grant_a = (state == StCoreLast);
                grant_c = !grant_a;
            end else begin
                grant_c = c_valid;
                grant_a = a_valid;
            end
        end
    end

    assign c_ready   = grant_c;
    assign a_ready   = grant_a;
    assign handshake = grant_c | grant_a;

    assign sel_addr = grant_a ? a_addr : c_addr;
    assign sel_data = grant_a ? a_data : c_data;
    assign sel_size = grant_a ? a_size : c_size;

    // Only the word-address, region and offset bits matter.
    assign unused_addr_bits = ^sel_addr;

    byte_lane_encoder #(
        .WIDTH (WIDTH)
    ) u_encoder (
        .size       (sel_size),
        .offset     (sel_addr[1:0]),
        .data       (sel_data),
        .mask       (enc_mask),
        .wdata      (enc_wdata),
        .misaligned (enc_misaligned)
    );

    // Region decode from the top address nibble.
    always_comb begin
        dmem_hit = 1'b0;
        imem_hit = 1'b0;
        case (sel_addr[31:28])
            REGION_DMEM: dmem_hit = 1'b1;
            REGION_IMEM: imem_hit = 1'b1;
            REGION_BOTH: begin
                dmem_hit = 1'b1;
                imem_hit = 1'b1;
            end
            default: ;
        endcase
    end

    // Arbitration state plus the registered command outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dmem_we   <= 4'b0000;
            imem_we   <= 4'b0000;
            err_pulse <= 1'b0;
            err_src   <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            dmem_we   <= 4'b0000;
            imem_we   <= 4'b0000;
            err_pulse <= 1'b0;

            if (grant_a) begin
                state <= a_lock ? StAuxLocked : StAuxLast;
            end else if (grant_c) begin
                state <= StCoreLast;
            end else if ((state == StAuxLocked) && !a_lock) begin
                state <= StAuxLast;
            end

            if (handshake) begin
                mem_addr  <= sel_addr[ADDR_W+1:2];
                mem_wdata <= enc_wdata;
                if (enc_misaligned) begin
                    // Consumed without writing; count saturates.
                    err_pulse <= 1'b1;
                    err_src   <= grant_a;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end else begin
                    dmem_we <= dmem_hit ? enc_mask : 4'b0000;
                    imem_we <= (imem_hit && imem_wr_allow) ? enc_mask : 4'b0000;
                end
            end
        end
    end

endmodule

// File: doc/mem_write_arbiter.md
MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width.
REQ-002 SHALL have parameter ADDR_W, default 14, word-address width driven to the memories.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port c_valid  input  1  core store request valid.
REQ-006 SHALL have port c_ready  output  1  core request accepted this cycle.
REQ-007 SHALL have ports c_addr, c_data (input, WIDTH each) and c_size (input, 2): core byte address, unshifted store data and size (00 byte, 01 half, 10 word, 11 illegal).
REQ-008 SHALL have ports a_valid, a_ready, a_addr, a_data and a_size: the auxiliary (loader) requester, with the same widths and meanings as the core ports.
REQ-009 SHALL have port a_lock  input  1  aux requests back-to-back ownership.
REQ-010 SHALL have port imem_wr_allow  input  1  permits IMEM writes.
REQ-011 SHALL have port mem_addr  output  ADDR_W  word address, addr[ADDR_W+1:2].
REQ-012 SHALL have port mem_wdata  output  WIDTH  lane-aligned write data.
REQ-013 SHALL have ports dmem_we and imem_we  output  4 each  byte write enables.
REQ-014 SHALL have ports err_pulse (output, 1) and err_src (output, 1): one-cycle misalignment/illegal-size flag, and its source (0 core, 1 aux).
REQ-015 SHALL have port err_cnt  output  8  saturating error count.

Function
REQ-016 Handshake SHALL occur when valid and ready are both high; at most one requester is granted per cycle; ready SHALL depend combinationally on both valids and on the state.
REQ-017 Arbitration SHALL use states IDLE, CORE_LAST, AUX_LAST and AUX_LOCKED.
REQ-018 When one requester is valid, it SHALL be granted.
REQ-019 When both are valid, the requester not served last SHALL be granted (IDLE favours core).
REQ-020 After an aux handshake with a_lock=1, the state SHALL be AUX_LOCKED; in AUX_LOCKED, c_ready SHALL be 0.
REQ-021 AUX_LOCKED SHALL exit to AUX_LAST on the first cycle a_lock=0.
REQ-022 On a handshake, the command SHALL be registered; outputs reflect it exactly one cycle later, giving a latency of 1.
REQ-023 A new handshake SHALL be allowed every cycle, with no bubbles.
REQ-024 Byte mask SHALL be 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half) or 1111 (word).
REQ-025 mem_wdata SHALL be data<<(8*addr[1:0]) for byte and half, and data unchanged for word.
REQ-026 Region decode SHALL use addr[31:28]: 0001 selects DMEM, 0010 selects IMEM, 0011 selects both, any other value selects neither.
REQ-027 imem_we SHALL be nonzero only if imem_wr_allow=1 at the handshake cycle.
REQ-028 Misalignment SHALL be defined as: half with addr[0]=1, word with addr[1:0]!=00, or size 11.
REQ-029 A misaligned request SHALL be consumed: both enables 0, err_pulse=1 and err_src set in the output cycle, err_cnt+1 saturating at 255.
REQ-030 An unmapped region SHALL be consumed silently, with both enables 0 and no error.
REQ-031 In cycles without a prior-cycle handshake, dmem_we, imem_we and err_pulse SHALL be 0; mem_addr and mem_wdata hold their last value.

Reset
REQ-032 rst_n low SHALL immediately force: all outputs 0, state IDLE, err_cnt 0, c_ready and a_ready 0.
REQ-033 A command registered before reset SHALL be discarded and never written.
REQ-034 The first grant after rst_n rises SHALL be no earlier than the next rising edge.

Structure
REQ-035 Package mem_wr_pkg SHALL hold size encodings, region codes (REGION_DMEM, REGION_IMEM, REGION_BOTH) and the arbiter state enum.
REQ-036 Sub-module byte_lane_encoder SHALL be combinational, map (size, addr[1:0], data) to (mask, shifted data, misaligned), and be instantiated once after the grant mux.

Verification
REQ-037 SHALL verify: core only, c_addr=0x1000_0006, size 01, data 0x0000_ABCD -> next cycle dmem_we=1100, mem_wdata=0xABCD_0000, mem_addr=1, imem_we=0000.
REQ-038 SHALL verify: both valid for 4 cycles, a_lock=0, from IDLE -> grants core, aux, core, aux; outputs follow one cycle behind.
REQ-039 SHALL verify: aux granted with a_lock=1 for 3 cycles while c_valid=1 -> c_ready=0 throughout; core granted the cycle after a_lock falls.
REQ-040 SHALL verify: c_addr=0x3000_0000, word, imem_wr_allow=0 -> dmem_we=1111, imem_we=0000; repeat with allow=1 -> both 1111.
REQ-041 SHALL verify: a_addr=0x1000_0002, word -> no enables, err_pulse=1, err_src=1, err_cnt=1; 300 such requests -> err_cnt=255.
REQ-042 SHALL verify: rst_n asserted in the cycle after a handshake -> enables stay 0 asynchronously, no write occurs, err_cnt=0.
